// File: rtl/vrf_multiport_if.sv
// Bus bundle for vrf_multiport: read ports, masked write port and init status.
// master = issue/writeback side, slave = register file.
interface vrf_multiport_if #(
    parameter int unsigned VREGS      = 32,
    parameter int unsigned ELEMENTS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_PORTS   = 3
);
    localparam int unsigned AW = $clog2(VREGS);

    logic                                             init_done;
    logic [RD_PORTS-1:0]                              rd_en;
    logic [RD_PORTS-1:0][AW-1:0]                      rd_addr;
    logic [RD_PORTS-1:0]                              rd_valid;
    logic [RD_PORTS-1:0][ELEMENTS-1:0][DATA_WIDTH-1:0] data_out;
    logic [ELEMENTS-1:0]                              v_wr_en;
    logic [AW-1:0]                                    v_wr_addr;
    logic [ELEMENTS*DATA_WIDTH-1:0]                   v_wr_data;

    modport master (
        input  init_done, rd_valid, data_out,
        output rd_en, rd_addr, v_wr_en, v_wr_addr, v_wr_data
    );

    modport slave (
        output init_done, rd_valid, data_out,
        input  rd_en, rd_addr, v_wr_en, v_wr_addr, v_wr_data
    );
endinterface

// File: rtl/vrf_multiport.sv
// Multi-port vector register file with per-element write mask and post-reset zero-init.
// Define CELLRV32_VRF_BYPASS_EN for same-cycle per-element write-to-read forwarding.
module vrf_multiport #(
    parameter int unsigned VREGS      = 32,
    parameter int unsigned ELEMENTS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_PORTS   = 3
) (
    input  logic           clk_i,
    input  logic           reset,
    vrf_multiport_if.slave vif
);
    localparam int unsigned AW = $clog2(VREGS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef logic [ELEMENTS-1:0][DATA_WIDTH-1:0] vreg_t;

    state_t                  state_q;
    logic [AW-1:0]           cnt_q;
    logic                    init_done_q;
    logic [RD_PORTS-1:0]     rd_valid_q;
    vreg_t                   data_out_q [RD_PORTS];
    vreg_t                   rd_data_d  [RD_PORTS];
    vreg_t                   mem_q      [VREGS];

    // Storage has no reset; its contents are defined by the init sequencer.
    always_ff @(posedge clk_i) begin
        if (state_q == S_INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int unsigned e = 0; e < ELEMENTS; e++) begin
                if (vif.v_wr_en[e]) begin
                    mem_q[vif.v_wr_addr][e] <= vif.v_wr_data[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            rd_data_d[p] = mem_q[vif.rd_addr[p]];
`ifdef CELLRV32_VRF_BYPASS_EN
            if (vif.rd_addr[p] == vif.v_wr_addr) begin
                for (int unsigned e = 0; e < ELEMENTS; e++) begin
                    if (vif.v_wr_en[e]) begin
                        rd_data_d[p][e] = vif.v_wr_data[e*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= '0;
            for (int unsigned p = 0; p < RD_PORTS; p++) begin
                data_out_q[p] <= '0;
            end
        end else begin
            case (state_q)
                S_INIT: begin
                    rd_valid_q <= '0;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == AW'(VREGS - 1)) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    rd_valid_q <= vif.rd_en;
                    for (int unsigned p = 0; p < RD_PORTS; p++) begin
                        if (vif.rd_en[p]) begin
                            data_out_q[p] <= rd_data_d[p];
                        end
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign vif.init_done = init_done_q;
    assign vif.rd_valid  = rd_valid_q;

    always_comb begin
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            vif.data_out[p] = data_out_q[p];
        end
    end
endmodule

// File: tb/tb_vrf_multiport.sv
// Self-checking bench for vrf_multiport: directed plan steps plus random traffic
// checked against an array-based register file model.
module tb_vrf_multiport;
    localparam int unsigned VREGS = 32;
    localparam int unsigned ELEMENTS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RDP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vrf_multiport_if #(.VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DW), .RD_PORTS(RDP)) vif ();

    vrf_multiport #(.VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DW), .RD_PORTS(RDP)) dut (
        .clk_i (clk),
        .reset (rst),
        .vif   (vif.slave)
    );

    logic [DW-1:0]            mem    [VREGS][ELEMENTS];
    logic [ELEMENTS*DW-1:0]   exp_do [RDP];
    logic                     exp_vld[RDP];
    bit                       run;
    int                       init_cnt;
    int                       checks = 0;
    int                       errors = 0;

    task automatic check(input string tag, input logic [ELEMENTS*DW-1:0] obs,
                         input logic [ELEMENTS*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, " init_done"}, {127'b0, vif.init_done}, {127'b0, run});
        for (int p = 0; p < RDP; p++) begin
            check($sformatf("%s rd_valid[%0d]", where, p), {127'b0, vif.rd_valid[p]}, {127'b0, exp_vld[p]});
            check($sformatf("%s data_out[%0d]", where, p), vif.data_out[p], exp_do[p]);
        end
    endtask

    task automatic model_reset();
        run = 0;
        init_cnt = 0;
        for (int p = 0; p < RDP; p++) begin
            exp_do[p] = '0;
            exp_vld[p] = 1'b0;
        end
    endtask

    task automatic idle();
        vif.rd_en = '0;
        vif.rd_addr = '0;
        vif.v_wr_en = '0;
        vif.v_wr_addr = '0;
        vif.v_wr_data = '0;
    endtask

    // Advance the model over one edge using the currently driven inputs, then clock and compare.
    task automatic step(input string where);
        if (!run) begin
            for (int e = 0; e < ELEMENTS; e++) mem[init_cnt][e] = '0;
            init_cnt++;
            if (init_cnt == VREGS) run = 1;
            for (int p = 0; p < RDP; p++) exp_vld[p] = 1'b0;
        end else begin
            for (int p = 0; p < RDP; p++) begin
                exp_vld[p] = vif.rd_en[p];
                if (vif.rd_en[p]) begin
                    for (int e = 0; e < ELEMENTS; e++) begin
                        exp_do[p][e*DW +: DW] = mem[vif.rd_addr[p]][e];
`ifdef CELLRV32_VRF_BYPASS_EN
                        if (vif.rd_addr[p] == vif.v_wr_addr && vif.v_wr_en[e])
                            exp_do[p][e*DW +: DW] = vif.v_wr_data[e*DW +: DW];
`endif
                    end
                end
            end
            for (int e = 0; e < ELEMENTS; e++)
                if (vif.v_wr_en[e]) mem[vif.v_wr_addr][e] = vif.v_wr_data[e*DW +: DW];
        end
        @(posedge clk);
        #1;
        check_outputs(where);
    endtask

    task automatic do_reset(input int cycles);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async reset");
        repeat (cycles) @(posedge clk);
        #1;
        check_outputs("in reset");
        rst = 1'b0;
    endtask

    task automatic write(input int addr, input logic [ELEMENTS-1:0] en, input logic [DW-1:0] word);
        idle();
        vif.v_wr_addr = addr[4:0];
        vif.v_wr_en = en;
        vif.v_wr_data = {ELEMENTS{word}};
        step("write");
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        for (int r = 0; r < VREGS; r++)
            for (int e = 0; e < ELEMENTS; e++) mem[r][e] = 'x;

        // Init with blocked write/read attempts on v0.
        do_reset(3);
        for (int i = 0; i < VREGS; i++) begin
            vif.v_wr_en = '1;
            vif.v_wr_addr = '0;
            vif.v_wr_data = {ELEMENTS{32'hDEAD_BEEF}};
            vif.rd_en = '1;
            vif.rd_addr = '0;
            step("init");
        end
        check("init_done after VREGS edges", {127'b0, vif.init_done}, 128'd1);
        for (int i = 0; i < VREGS; i++) begin
            idle();
            vif.rd_en[0] = 1'b1;
            vif.rd_addr[0] = i[4:0];
            step("init readback");
        end
        check("v31 zero", vif.data_out[0], '0);

        // Masked write.
        write(5, 4'b1111, 32'hAAAA_AAAA);
        write(5, 4'b0101, 32'h1234_5678);
        idle();
        vif.rd_en[0] = 1'b1;
        vif.rd_addr[0] = 5'd5;
        step("masked read");
        check("masked const", vif.data_out[0], {32'hAAAA_AAAA, 32'h1234_5678, 32'hAAAA_AAAA, 32'h1234_5678});

        // Multi-port read.
        write(1, 4'hF, 32'h1);
        write(2, 4'hF, 32'h2);
        idle();
        vif.rd_en = 3'b111;
        vif.rd_addr[0] = 5'd1;
        vif.rd_addr[1] = 5'd2;
        vif.rd_addr[2] = 5'd1;
        step("multiport");
        check("mp port1 const", vif.data_out[1], {4{32'h2}});
        idle();
        step("multiport hold");
        check("mp hold const", vif.data_out[2], {4{32'h1}});

        // Same-cycle collision.
        write(7, 4'hF, 32'hFFFF_FFFF);
        idle();
        vif.v_wr_addr = 5'd7;
        vif.v_wr_en = 4'b0011;
        vif.v_wr_data = '0;
        vif.rd_en[0] = 1'b1;
        vif.rd_addr[0] = 5'd7;
        step("collision");
`ifdef CELLRV32_VRF_BYPASS_EN
        check("collision const", vif.data_out[0], {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0});
`else
        check("collision const", vif.data_out[0], {4{32'hFFFF_FFFF}});
`endif
        idle();
        vif.rd_en[0] = 1'b1;
        vif.rd_addr[0] = 5'd7;
        step("after collision");
        check("after collision const", vif.data_out[0], {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0});

        // Reset mid-run.
        write(3, 4'hF, 32'h5555_5555);
        idle();
        do_reset(2);
        for (int i = 0; i < VREGS; i++) step("reinit");
        vif.rd_en[1] = 1'b1;
        vif.rd_addr[1] = 5'd3;
        step("v3 after reinit");
        check("v3 zero const", vif.data_out[1], '0);

        // Random traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            vif.rd_en = 3'($urandom);
            for (int p = 0; p < RDP; p++) vif.rd_addr[p] = 5'($urandom_range(0, 7));
            vif.v_wr_en = 4'($urandom);
            vif.v_wr_addr = 5'($urandom_range(0, 7));
            for (int e = 0; e < ELEMENTS; e++) vif.v_wr_data[e*DW +: DW] = $urandom;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
